race_state_fsm: RTL and testbench

RACE_STATE_FSM -- requirements
Module: race_state_fsm

---
 rtl/race_state_fsm.sv | 169 ++++++++++++++++
 tb/tb_race_state_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/race_state_fsm.sv
// Race game controller: menu, peer sync, countdown, timed race with pause,
// and finish. All outputs registered; one clock domain.
module race_state_fsm #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int COUNT_SECS    = 3,
  parameter int MAX_RACE_SECS = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic       setting_pulse,
  input  logic       sync_ok,
  input  logic       pause_pulse,
  input  logic       finish_in,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [9:0] race_secs,
  output logic       sec_tick
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [1:0] CD_LOAD = 2'(COUNT_SECS);
  localparam logic [9:0] RACE_MAX = 10'(MAX_RACE_SECS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTING   = 3'd1,
    SYNCING   = 3'd2,
    COUNTDOWN = 3'd3,
    RACING    = 3'd4,
    PAUSE     = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t           state_q, state_n;
  logic [1:0]       countdown_q, countdown_n;
  logic [9:0]       race_secs_q, race_secs_n;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_n;
  logic             sec_tick_q, sec_tick_n;
  logic             wrap;
  logic [SUB_W-1:0] sub_inc;

  assign wrap    = (sub_cnt_q == SUB_LAST);
  assign sub_inc = wrap ? '0 : sub_cnt_q + SUB_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      countdown_q <= '0;
      race_secs_q <= '0;
      sub_cnt_q   <= '0;
      sec_tick_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      countdown_q <= countdown_n;
      race_secs_q <= race_secs_n;
      sub_cnt_q   <= sub_cnt_n;
      sec_tick_q  <= sec_tick_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    countdown_n = countdown_q;
    race_secs_n = race_secs_q;
    sub_cnt_n   = sub_cnt_q;
    sec_tick_n  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_n = SYNCING;
        end else if (setting_pulse) begin
          state_n = SETTING;
        end
      end

      SETTING: begin
        if (setting_pulse) begin
          state_n     = IDLE;
          countdown_n = '0;
          race_secs_n = '0;
          sub_cnt_n   = '0;
        end
      end

      SYNCING: begin
        if (sync_ok) begin
          state_n     = COUNTDOWN;
          countdown_n = CD_LOAD;
          sub_cnt_n   = '0;
        end else if (start_pulse) begin
          state_n     = IDLE;
          countdown_n = '0;
          race_secs_n = '0;
          sub_cnt_n   = '0;
        end
      end

      COUNTDOWN: begin
        sub_cnt_n  = sub_inc;
        sec_tick_n = wrap;
        if (wrap) begin
          if (countdown_q <= 2'd1) begin
            state_n     = RACING;
            countdown_n = '0;
            race_secs_n = '0;
            sub_cnt_n   = '0;
          end else begin
            countdown_n = countdown_q - 2'd1;
          end
        end
      end

      RACING: begin
        sub_cnt_n  = sub_inc;
        sec_tick_n = wrap;
        // Saturation and finish_in both end the race; pause only applies otherwise.
        if (wrap) begin
          if (race_secs_q >= RACE_MAX - 10'd1) begin
            race_secs_n = RACE_MAX;
            state_n     = FINISH;
          end else begin
            race_secs_n = race_secs_q + 10'd1;
          end
        end
        if (finish_in) begin
          state_n = FINISH;
        end else if (pause_pulse && state_n == RACING) begin
          state_n = PAUSE;
        end
      end

      PAUSE: begin
        if (start_pulse) begin
          state_n     = IDLE;
          countdown_n = '0;
          race_secs_n = '0;
          sub_cnt_n   = '0;
        end else if (pause_pulse) begin
          state_n = RACING;
        end
      end

      FINISH: begin
        if (start_pulse) begin
          state_n     = IDLE;
          countdown_n = '0;
          race_secs_n = '0;
          sub_cnt_n   = '0;
        end
      end

      default: begin
        state_n     = IDLE;
        countdown_n = '0;
        race_secs_n = '0;
        sub_cnt_n   = '0;
      end
    endcase
  end

  assign state     = state_q;
  assign countdown = countdown_q;
  assign race_secs = race_secs_q;
  assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_race_state_fsm.sv
// Scoreboard bench for race_state_fsm: stimulus pushes timed expectations,
// a negedge monitor pops and compares them.
module tb_race_state_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_pulse = 1'b0;
  logic       setting_pulse = 1'b0;
  logic       sync_ok = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       finish_in = 1'b0;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [9:0] race_secs;
  logic       sec_tick;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         at;
    string      tag;
    logic [2:0] st;
    logic [1:0] cd;
    logic [9:0] rs;
    logic       tk;
  } exp_t;

  exp_t sb[$];

  race_state_fsm #(
    .TICKS_PER_SEC(10),
    .COUNT_SECS(3),
    .MAX_RACE_SECS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_pulse(start_pulse),
    .setting_pulse(setting_pulse),
    .sync_ok(sync_ok),
    .pause_pulse(pause_pulse),
    .finish_in(finish_in),
    .state(state),
    .countdown(countdown),
    .race_secs(race_secs),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has come due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (e.at != cyc || state !== e.st || countdown !== e.cd ||
          race_secs !== e.rs || sec_tick !== e.tk) begin
        miscompares++;
        $display("[TB] FAIL %s @cyc %0d: got state=%0d cd=%0d rs=%0d tick=%0b, want state=%0d cd=%0d rs=%0d tick=%0b (due %0d)",
                 e.tag, cyc, state, countdown, race_secs, sec_tick,
                 e.st, e.cd, e.rs, e.tk, e.at);
      end
    end
  end

  task automatic checkOutput(input string tag, input int d, input logic [2:0] st,
                             input logic [1:0] cd, input logic [9:0] rs, input logic tk);
    exp_t e;
    e.at  = cyc + d;
    e.tag = tag;
    e.st  = st;
    e.cd  = cd;
    e.rs  = rs;
    e.tk  = tk;
    sb.push_back(e);
  endtask

  // Drive one-cycle pulses for exactly one sampling edge.
  task automatic applyStimulus(input logic st, input logic se, input logic pa, input logic fi);
    start_pulse   = st;
    setting_pulse = se;
    pause_pulse   = pa;
    finish_in     = fi;
    @(negedge clk);
    start_pulse   = 1'b0;
    setting_pulse = 1'b0;
    pause_pulse   = 1'b0;
    finish_in     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enterRacing();
    checkOutput("sync_enter", 1, 3'd2, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sync_ok = 1'b1;
    checkOutput("cd_load", 1, 3'd3, 2'd3, 10'd0, 1'b0);
    @(negedge clk);
    sync_ok = 1'b0;
    checkOutput("cd_hold", 9, 3'd3, 2'd3, 10'd0, 1'b0);
    checkOutput("cd_2", 10, 3'd3, 2'd2, 10'd0, 1'b1);
    checkOutput("cd_gap", 11, 3'd3, 2'd2, 10'd0, 1'b0);
    checkOutput("cd_1", 20, 3'd3, 2'd1, 10'd0, 1'b1);
    checkOutput("race_go", 30, 3'd4, 2'd0, 10'd0, 1'b1);
    idle(30);
  endtask

  task automatic backToIdle(input string tag);
    checkOutput(tag, 1, 3'd0, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d expectations pending", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    checkOutput("reset", 1, 3'd0, 2'd0, 10'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Settings menu toggles in and out.
    checkOutput("menu_in", 1, 3'd1, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("menu_ignore_start", 1, 3'd1, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("menu_out", 1, 3'd0, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Start beats setting; start in SYNCING without peer aborts.
    checkOutput("start_wins", 1, 3'd2, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("sync_wait", 1, 3'd2, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort", 1, 3'd0, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Full flow then saturation at 5 seconds.
    enterRacing();
    checkOutput("rs1", 10, 3'd4, 2'd0, 10'd1, 1'b1);
    checkOutput("rs1_gap", 11, 3'd4, 2'd0, 10'd1, 1'b0);
    checkOutput("rs2", 20, 3'd4, 2'd0, 10'd2, 1'b1);
    checkOutput("rs3", 30, 3'd4, 2'd0, 10'd3, 1'b1);
    checkOutput("rs4", 40, 3'd4, 2'd0, 10'd4, 1'b1);
    checkOutput("sat_finish", 50, 3'd6, 2'd0, 10'd5, 1'b1);
    checkOutput("sat_hold", 51, 3'd6, 2'd0, 10'd5, 1'b0);
    idle(51);
    checkOutput("fin_ignore", 1, 3'd6, 2'd0, 10'd5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    backToIdle("fin_exit");

    // Pause with sub_cnt held at 4 during second 2, then resume.
    enterRacing();
    checkOutput("p_rs2", 20, 3'd4, 2'd0, 10'd2, 1'b1);
    idle(23);
    checkOutput("paused", 1, 3'd5, 2'd0, 10'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pause_hold", 50, 3'd5, 2'd0, 10'd2, 1'b0);
    idle(50);
    checkOutput("resume", 1, 3'd4, 2'd0, 10'd2, 1'b0);
    checkOutput("pre_tick", 6, 3'd4, 2'd0, 10'd2, 1'b0);
    checkOutput("resume_tick", 7, 3'd4, 2'd0, 10'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    checkOutput("fin_over_pause", 1, 3'd6, 2'd0, 10'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    backToIdle("idle2");

    // finish_in on the wrap cycle still counts the second.
    enterRacing();
    idle(9);
    checkOutput("fin_wrap", 1, 3'd6, 2'd0, 10'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    backToIdle("idle3");

    // Reset mid-countdown with start held high.
    checkOutput("sync_enter2", 1, 3'd2, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sync_ok = 1'b1;
    checkOutput("cd_load2", 1, 3'd3, 2'd3, 10'd0, 1'b0);
    @(negedge clk);
    sync_ok = 1'b0;
    checkOutput("cd_pre_rst", 12, 3'd3, 2'd2, 10'd0, 1'b0);
    idle(12);
    rst = 1'b1;
    checkOutput("rst_mid", 1, 3'd0, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("post_rst", 1, 3'd2, 2'd0, 10'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    idle(3);
    if (sb.size() != 0) begin
      $display("[TB] FAIL pending: %0d expectations never checked, want 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
